aes_iter_core: RTL and testbench
================================

AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL provide parameter ROUNDS_PER_CYCLE, default 1, AES rounds computed per clock; legal values 1, 2, 5, 10; any other value SHALL cause an elaboration error.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  plaintext/key block offered.
REQ-005 SHALL provide port in_ready  output  1  core accepts a block this cycle.
REQ-006 SHALL provide port in_data  input  128  plaintext; [127:120] = byte 0 = state[0][0], column-major per FIPS-197.
REQ-007 SHALL provide port in_key  input  128  cipher key, same byte order as in_data.
REQ-008 SHALL provide port out_valid  output  1  ciphertext available.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL provide port out_data  output  128  ciphertext, same byte order as in_data.
REQ-011 SHALL provide port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement AES-128 encryption only: 10 rounds, on-the-fly key expansion, no stored key schedule.
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be high only in IDLE; a transfer occurs on a rising edge with in_valid and in_ready both high.
REQ-015 On transfer, SHALL register state = in_data XOR in_key and round key = in_key, clear the round counter, and enter RUN.
REQ-016 In RUN, each clock SHALL apply ROUNDS_PER_CYCLE rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and advance the round key and round constant accordingly.
REQ-017 Round 10 SHALL omit MixColumns.
REQ-018 The round counter SHALL be 4 bits, count 0..10, and not wrap.
REQ-019 out_valid SHALL rise exactly 10/ROUNDS_PER_CYCLE rising edges after the accepting edge; FSM enters DONE on that edge.
REQ-020 In DONE, out_valid and out_data SHALL hold stable until an edge with out_ready high; the FSM then returns to IDLE, and in_ready is high the following cycle.
REQ-021 Only one block SHALL be in flight; in_valid asserted outside IDLE SHALL be ignored, and in_data/in_key SHALL not be sampled.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 out_data SHALL be zero whenever out_valid is low.

Reset
REQ-024 rst_n low SHALL immediately, without a clock, force FSM to IDLE, clear state, round key, and counter, and drive in_ready=0, out_valid=0, out_data=0, busy=0.
REQ-025 in_ready SHALL go high on the first rising edge after rst_n deasserts.
REQ-026 Reset asserted in RUN or DONE SHALL discard the in-flight block; no out_valid SHALL be produced for it.

Configuration
REQ-027 Macro AES_KEY_HOLD_EN defined SHALL add port key_load  input  1.
REQ-028 With AES_KEY_HOLD_EN defined, in_key SHALL be latched into an internal key register only on a transfer with key_load high; otherwise the last latched key SHALL be used, and that register SHALL reset to zero.
REQ-029 With AES_KEY_HOLD_EN undefined, key_load SHALL not exist and in_key SHALL be sampled on every transfer.

Verification
REQ-030 Test 1: ROUNDS_PER_CYCLE=1, in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after acceptance.
REQ-031 Test 2: ASCII plaintext "Two One Nine Two", key "Thats my Kung Fu", for ROUNDS_PER_CYCLE 1, 2, 5, and 10 -> out_data=29c3505f571420f6402299b31a02d73a, with latency 10, 5, 2, and 1 edges respectively.
REQ-032 Test 3: hold out_ready=0 for 7 cycles in DONE while toggling in_valid and in_data -> out_data stable, in_ready=0, and no second block accepted.
REQ-033 Test 4: pulse rst_n low for 3 ns mid-RUN, between clock edges -> all outputs zero immediately, no out_valid for that block, and the next block encrypts correctly.
REQ-034 Test 5: back-to-back blocks with out_ready tied high -> accept-to-accept period is 10/ROUNDS_PER_CYCLE+2 cycles and each ciphertext matches the reference model.
REQ-035 Test 6 (AES_KEY_HOLD_EN): load the Test 1 key with key_load=1, then send the Test 1 plaintext with key_load=0 and in_key=0 -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_iter_core_if.sv
// aes_iter_core_if: block handshake bundle for aes_iter_core.
//   in_valid/in_ready/in_data/in_key   plaintext + key offer (master -> core)
//   out_valid/out_ready/out_data       ciphertext delivery (core -> master)
//   busy                               core holds a block (RUN or DONE)
//   key_load                           latch in_key on transfer (only with AES_KEY_HOLD_EN)
interface aes_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_KEY_HOLD_EN
  logic         key_load;
`endif
  modport master (
`ifdef AES_KEY_HOLD_EN
    output key_load,
`endif
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
`ifdef AES_KEY_HOLD_EN
    input  key_load,
`endif
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock, on-the-fly key expansion.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    aes_iter_core_if.slave: in_valid/in_ready/in_data/in_key, out_valid/out_ready/out_data, busy
//   Optional macro AES_KEY_HOLD_EN adds bus.key_load and an internal held key register.
module aes_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  aes_iter_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state, nxt;
  logic [127:0] st, rk, st_n, rk_n, key;
  logic [7:0]   rc, rc_n;
  logic [3:0]   cnt;
  logic         armed, accept;
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = r ^ (b[i] ? a : 8'h00);
      a = xt(a);
    end
    return r;
  endfunction
  // inverse as x^254 (square-and-multiply), which maps 0 to 0, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, v;
    p = x;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] c);
    logic [31:0] t, n0, n1, n2;
    t  = sub_word({k[23:0], k[31:24]}) ^ {c, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  // byte i sits at row i%4, column i/4; ShiftRows pulls row r from column c+r
  function automatic logic [127:0] round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t, m;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = sbox(s[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]);
    for (int c = 0; c < 4; c++)
      m[127-32*c -: 32] = mix_col(t[127-32*c -: 32]);
    return (last ? t : m) ^ k;
  endfunction
`ifdef AES_KEY_HOLD_EN
  logic [127:0] held;
  assign key = bus.key_load ? bus.in_key : held;
`else
  assign key = bus.in_key;
`endif
  assign accept = state == IDLE && armed && bus.in_valid;
  always_comb begin
    st_n = st;
    rk_n = rk;
    rc_n = rc;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      rk_n = next_key(rk_n, rc_n);
      st_n = round(st_n, rk_n, 32'(cnt) + i == 9);
      rc_n = xt(rc_n);
    end
  end
  always_comb begin
    bus.in_ready  = state == IDLE && armed;
    bus.out_valid = state == DONE;
    bus.out_data  = state == DONE ? st : '0;
    bus.busy      = state != IDLE;
    nxt = accept ? RUN :
          (state == RUN && cnt + 4'(ROUNDS_PER_CYCLE) == 4'd10) ? DONE :
          (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed <= 1'b0;
      st    <= '0;
      rk    <= '0;
      rc    <= '0;
      cnt   <= '0;
`ifdef AES_KEY_HOLD_EN
      held  <= '0;
`endif
    end else begin
      armed <= 1'b1;
      if (accept) begin
        st  <= bus.in_data ^ key;
        rk  <= key;
        rc  <= 8'h01;
        cnt <= '0;
`ifdef AES_KEY_HOLD_EN
        if (bus.key_load) held <= bus.in_key;
`endif
      end else if (state == RUN) begin
        st  <= st_n;
        rk  <= rk_n;
        rc  <= rc_n;
        cnt <= cnt + 4'(ROUNDS_PER_CYCLE);
      end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed + randomized bench for aes_iter_core at 1, 2, 5 and 10 rounds per cycle.
module tb_aes_iter_core;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] C2 = 128'h29c3505f571420f6402299b31a02d73a;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [3:0]   iv = '0, ordy = '0, rdy, ov, bz;
  logic [127:0] id[4], ik[4], od[4];
`ifdef AES_KEY_HOLD_EN
  logic [3:0]   kl = '0;
`endif
  int           checks = 0, failures = 0;
  logic [7:0]   sbt[256];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : u
    aes_iter_core_if b ();
    assign b.in_valid  = iv[g];
    assign b.in_data   = id[g];
    assign b.in_key    = ik[g];
    assign b.out_ready = ordy[g];
`ifdef AES_KEY_HOLD_EN
    assign b.key_load  = kl[g];
`endif
    assign rdy[g] = b.in_ready;
    assign ov[g]  = b.out_valid;
    assign od[g]  = b.out_data;
    assign bz[g]  = b.busy;
    aes_iter_core #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b)
    );
  end
  function automatic int rpc(input int g);
    return g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10;
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  // S-box from its definition: brute-force multiplicative inverse, then bitwise affine map
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[x] = s;
    end
  endtask
  // textbook AES-128: full 44-word schedule, byte-array state
  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   s[16], x[16], rc;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) x[k] = sbt[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        if (rd < 10) begin
          s[4*c]   = gm(x[4*c], 2) ^ gm(x[4*c+1], 3) ^ x[4*c+2] ^ x[4*c+3];
          s[4*c+1] = x[4*c] ^ gm(x[4*c+1], 2) ^ gm(x[4*c+2], 3) ^ x[4*c+3];
          s[4*c+2] = x[4*c] ^ x[4*c+1] ^ gm(x[4*c+2], 2) ^ gm(x[4*c+3], 3);
          s[4*c+3] = gm(x[4*c], 3) ^ x[4*c+1] ^ x[4*c+2] ^ gm(x[4*c+3], 2);
        end else for (int j = 0; j < 4; j++) s[4*c+j] = x[4*c+j];
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_block(input int g, input logic [127:0] pt, input logic [127:0] k, input bit rel,
                           output int lat, output logic [127:0] ct);
    int n = 0;
    @(negedge clk);
    while (!rdy[g] && n < 30) begin @(negedge clk); n++; end
    check("ready_wait", 128'(rdy[g]), 128'd1);
    id[g] = pt; ik[g] = k; iv[g] = 1'b1;
    @(posedge clk); #1 iv[g] = 1'b0;
    lat = 0;
    while (!ov[g] && lat < 40) begin @(posedge clk); #1; lat++; end
    ct = od[g];
    if (rel) begin
      @(negedge clk); ordy[g] = 1'b1;
      @(posedge clk); #1 ordy[g] = 1'b0;
    end
  endtask
  initial begin
    int lat, cyc, last, nout;
    bit seen;
    logic [127:0] ct, snap, p, k;
    logic [127:0] q[$];
    for (int g = 0; g < 4; g++) begin id[g] = '0; ik[g] = '0; end
    build_sbox();
    // reset state and in_ready release timing
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdy", 128'(rdy), 0);
    check("rst_ov", 128'(ov), 0);
    check("rst_busy", 128'(bz), 0);
    check("rst_od", od[0] | od[1] | od[2] | od[3], 0);
    rst_n = 1'b1;
    #1 check("rdy_before_edge", 128'(rdy), 0);
    @(posedge clk); #1 check("rdy_after_edge", 128'(rdy), 128'hf);
    // FIPS-197 vector, 1 round per cycle
    run_block(0, P1, K1, 1, lat, ct);
    check("kat1_ct", ct, C1);
    check("kat1_lat", 128'(lat), 10);
    // second vector at every unrolling
    for (int g = 0; g < 4; g++) begin
      run_block(g, P2, K2, 1, lat, ct);
      check("kat2_ct", ct, C2);
      check("kat2_lat", 128'(lat), 128'(10 / rpc(g)));
    end
    // DONE holds against in_valid/in_data noise
    run_block(0, P1, K1, 0, lat, ct);
    snap = ct;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      iv[0] = ~iv[0];
      id[0] = {$urandom, $urandom, $urandom, $urandom};
      check("hold_od", od[0], C1);
      check("hold_ov", 128'(ov[0]), 1);
      check("hold_rdy", 128'(rdy[0]), 0);
    end
    check("hold_snap", snap, C1);
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1 ordy[0] = 1'b0;
    check("release_ov", 128'(ov[0]), 0);
    check("release_od", od[0], 0);
    check("release_busy", 128'(bz[0]), 0);
    @(negedge clk) check("release_rdy", 128'(rdy[0]), 1);
    // asynchronous reset pulse mid-RUN
    id[0] = {$urandom, $urandom, $urandom, $urandom}; ik[0] = {$urandom, $urandom, $urandom, $urandom};
    iv[0] = 1'b1;
    @(posedge clk); #1 iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("arst_rdy", 128'(rdy), 0);
    check("arst_ov", 128'(ov), 0);
    check("arst_busy", 128'(bz), 0);
    check("arst_od", od[0] | od[1] | od[2] | od[3], 0);
    #2 rst_n = 1'b1;
    #1 check("arst_rdy_low", 128'(rdy[0]), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (ov[0]) seen = 1; end
    check("arst_no_ov", 128'(seen), 0);
    check("arst_rdy_back", 128'(rdy), 128'hf);
    p = {$urandom, $urandom, $urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, p, k, 1, lat, ct);
    check("post_rst_ct", ct, ref_enc(p, k));
    // back-to-back random blocks, out_ready tied high
    for (int g = 0; g < 4; g++) begin
      q.delete(); ordy[g] = 1'b1; iv[g] = 1'b1; cyc = 0; last = -1; nout = 0;
      while (nout < 4 && cyc < 200) begin
        @(negedge clk); cyc++;
        if (ov[g] && q.size() > 0) begin check("b2b_ct", od[g], q.pop_front()); nout++; end
        id[g] = {$urandom, $urandom, $urandom, $urandom};
        ik[g] = {$urandom, $urandom, $urandom, $urandom};
        if (rdy[g]) begin
          if (last >= 0) check("b2b_period", 128'(cyc - last), 128'(10 / rpc(g) + 2));
          last = cyc;
          q.push_back(ref_enc(id[g], ik[g]));
        end
      end
      iv[g] = 1'b0;
      check("b2b_count", 128'(nout), 4);
      repeat (15) @(negedge clk);
      ordy[g] = 1'b0;
    end
`ifdef AES_KEY_HOLD_EN
    kl[0] = 1'b1;
    run_block(0, P2, K1, 1, lat, ct);
    check("hold_load_ct", ct, ref_enc(P2, K1));
    kl[0] = 1'b0;
    run_block(0, P1, 128'h0, 1, lat, ct);
    check("hold_key_ct", ct, C1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
